// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate extender with a valid/ready stage and a
// two-entry skid buffer.
//   op 00 zero-extend, 01 sign-extend, 10 upper (lui form),
//   op 11 branch offset (sign-extend, then shift left by 2).
// Optional fire_out event counter on stat_cnt when EXT_PIPE_STAT_EN is defined.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] ext_out
`ifdef EXT_PIPE_STAT_EN
  ,
  output logic [31:0]      stat_cnt
`endif
);

  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] main_data_q,  main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q,  skid_data_d;

  logic             fire_in;
  logic             fire_out;
  logic [OUT_W-1:0] zext_w;
  logic [OUT_W-1:0] sext_w;
  logic [OUT_W-1:0] upper_w;
  logic [OUT_W-1:0] result_w;

  // The upstream sees a plain register: ready only while the skid is empty.
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign ext_out   = main_data_q;
  assign fire_in   = in_valid & in_ready;
  assign fire_out  = main_valid_q & out_ready;

  // Extension arithmetic; partial-select form keeps IN_W == OUT_W legal.
  always_comb begin
    zext_w = '0;
    zext_w[IN_W-1:0] = imm;
    sext_w = {OUT_W{imm[IN_W-1]}};
    sext_w[IN_W-1:0] = imm;
    upper_w = '0;
    upper_w[OUT_W-1 -: IN_W] = imm;
    unique case (op)
      2'b00:   result_w = zext_w;
      2'b01:   result_w = sext_w;
      2'b10:   result_w = upper_w;
      default: result_w = sext_w << 2;
    endcase
  end

  // Next-state for main and skid entries.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!main_valid_q) begin
      // Skid can never hold data while main is empty.
      if (fire_in) begin
        main_valid_d = 1'b1;
        main_data_d  = result_w;
      end
    end else if (fire_out) begin
      if (skid_valid_q) begin
        // in_ready was low, so no new accept competes with the drain.
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (fire_in) begin
        main_data_d  = result_w;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (fire_in) begin
      skid_valid_d = 1'b1;
      skid_data_d  = result_w;
    end
  end

  // Pipeline registers; reset discards both entries at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

`ifdef EXT_PIPE_STAT_EN
  logic [31:0] stat_cnt_q, stat_cnt_d;

  assign stat_cnt_d = fire_out ? stat_cnt_q + 32'd1 : stat_cnt_q;
  assign stat_cnt   = stat_cnt_q;

  // Free-running count of delivered results, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stat_cnt_q <= '0;
    else       stat_cnt_q <= stat_cnt_d;
  end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Testbench for ext_pipe: directed scenarios plus randomized traffic checked
// against a queue-based reference model. A second instance covers 8->16.
module tb_ext_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] imm;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ext_out;

  logic        n_in_valid;
  logic        n_in_ready;
  logic [7:0]  n_imm;
  logic [1:0]  n_op;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [15:0] n_ext_out;

`ifdef EXT_PIPE_STAT_EN
  logic [31:0] stat_cnt;
  logic [31:0] n_stat_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0]      mq[$];
  int unsigned      stat_m = 0;

  ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .ext_out(ext_out)
`ifdef EXT_PIPE_STAT_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  ext_pipe #(.IN_W(8), .OUT_W(16)) dut_n (
    .clk(clk), .reset(reset),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .imm(n_imm), .op(n_op),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .ext_out(n_ext_out)
`ifdef EXT_PIPE_STAT_EN
    , .stat_cnt(n_stat_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Reference: extension as arithmetic modulo 2^ow.
  function automatic longint unsigned ref_ext(input longint unsigned v, input int o,
                                              input int iw, input int ow);
    longint unsigned one = 1;
    longint unsigned mod_o = one << ow;
    longint unsigned s;
    s = (v >= (one << (iw - 1))) ? v + mod_o - (one << iw) : v;
    case (o)
      0:       return v;
      1:       return s;
      2:       return (v * (one << (ow - iw))) % mod_o;
      default: return (s * 4) % mod_o;
    endcase
  endfunction

  // Drive one cycle on the main instance and advance the model.
  // The model only knows occupancy: ready while fewer than two are held.
  task automatic drive(input bit v, input logic [15:0] im, input logic [1:0] o, input bit ordy);
    bit fi, fo;
    in_valid  = v;
    imm       = im;
    op        = o;
    out_ready = ordy;
    fi = v && (mq.size() < 2);
    fo = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (fo) begin
      void'(mq.pop_front());
      stat_m++;
    end
    if (fi) mq.push_back(32'(ref_ext(64'(im), int'(o), 16, 32)));
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; imm = '0; op = '0; out_ready = 1'b0;
    n_in_valid = 1'b0; n_imm = '0; n_op = '0; n_out_ready = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (ext_out !== 32'h0) begin
      errors++; $display("FAIL reset_ext_out: got %h want 00000000", ext_out);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_modes();
    logic [31:0] exp_c [4];
    exp_c = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h8001, 2'(i), 1'b1);
      checks++;
      if (out_valid !== 1'b1 || ext_out !== exp_c[i]) begin
        errors++;
        $display("FAIL mode_op%0d: got valid=%b data=%h want 1/%h", i, out_valid, ext_out, exp_c[i]);
      end
      checks++;
      if (mq.size() != 1 || ext_out !== mq[0]) begin
        errors++; $display("FAIL mode_model_op%0d: got %h want model head", i, ext_out);
      end
    end
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mode_drain: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_positive();
    drive(1'b1, 16'h7FFF, 2'd3, 1'b1);
    checks++;
    if (ext_out !== 32'h0001FFFC) begin
      errors++; $display("FAIL pos_branch: got %h want 0001fffc", ext_out);
    end
    drive(1'b1, 16'h7FFF, 2'd1, 1'b1);
    checks++;
    if (ext_out !== 32'h00007FFF) begin
      errors++; $display("FAIL pos_sign: got %h want 00007fff", ext_out);
    end
    drive(1'b0, 16'h0, 2'd0, 1'b1);
  endtask

  task automatic test_backpressure();
    drive(1'b1, 16'h0001, 2'd0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || ext_out !== 32'h1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_accept_a: got v=%b d=%h r=%b want 1/1/1", out_valid, ext_out, in_ready);
    end
    drive(1'b1, 16'h0002, 2'd0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || ext_out !== 32'h1) begin
      errors++; $display("FAIL bp_accept_b: got r=%b d=%h want 0/1", in_ready, ext_out);
    end
    drive(1'b1, 16'h0003, 2'd0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || ext_out !== 32'h1) begin
      errors++; $display("FAIL bp_hold_c: got r=%b v=%b d=%h want 0/1/1", in_ready, out_valid, ext_out);
    end
    drive(1'b1, 16'h0003, 2'd0, 1'b1);
    checks++;
    if (ext_out !== 32'h2 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_out_b: got d=%h r=%b v=%b want 2/1/1", ext_out, in_ready, out_valid);
    end
    drive(1'b1, 16'h0003, 2'd0, 1'b1);
    checks++;
    if (ext_out !== 32'h3 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_out_c: got d=%h v=%b want 3/1", ext_out, out_valid);
    end
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_no_dup: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 16'h0011, 2'd0, 1'b0);
    drive(1'b1, 16'h0022, 2'd0, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_fill: got ready=%b want 0", in_ready);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ext_out !== 32'h0) begin
      errors++; $display("FAIL rst_async: got v=%b r=%b d=%h want 0/1/0", out_valid, in_ready, ext_out);
    end
    mq.delete();
    stat_m = 0;
    #2;
    reset = 1'b0;
    drive(1'b1, 16'h00FF, 2'd1, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || ext_out !== 32'h000000FF) begin
      errors++; $display("FAIL rst_after: got v=%b d=%h want 1/000000ff", out_valid, ext_out);
    end
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_stale: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_param();
    logic [15:0] exp_n [4];
    exp_n = '{16'h0080, 16'hFF80, 16'h8000, 16'hFE00};
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_in_valid = 1'b1; n_imm = 8'h80; n_op = 2'(i); n_out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (n_out_valid !== 1'b1 || n_ext_out !== exp_n[i]) begin
        errors++;
        $display("FAIL param_op%0d: got v=%b d=%h want 1/%h", i, n_out_valid, n_ext_out, exp_n[i]);
      end
      checks++;
      if (n_ext_out !== 16'(ref_ext(64'h80, i, 8, 16))) begin
        errors++; $display("FAIL param_model_op%0d: got %h want %h", i, n_ext_out, 16'(ref_ext(64'h80, i, 8, 16)));
      end
    end
    n_in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (n_out_valid !== 1'b0) begin
      errors++; $display("FAIL param_drain: got valid=%b want 0", n_out_valid);
    end
  endtask

  task automatic test_random();
    bit v, r;
    int bad = 0;
    for (int c = 0; c < 600; c++) begin
      v = ($urandom_range(0, 3) != 0);
      r = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      drive(v, 16'($urandom), 2'($urandom), r);
      checks++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
          (mq.size() > 0 && ext_out !== mq[0])) begin
        errors++;
        if (bad < 10)
          $display("FAIL rand_c%0d: got v=%b r=%b d=%h want v=%b r=%b d=%h", c, out_valid, in_ready,
                   ext_out, mq.size() > 0, mq.size() < 2, (mq.size() > 0) ? mq[0] : 32'h0);
        bad++;
      end
    end
    for (int k = 0; k < 4; k++) drive(1'b0, 16'h0, 2'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || mq.size() != 0) begin
      errors++; $display("FAIL rand_drain: got valid=%b want 0 (model left %0d)", out_valid, mq.size());
    end
  endtask

`ifdef EXT_PIPE_STAT_EN
  task automatic test_stat();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    mq.delete();
    stat_m = 0;
    drive(1'b1, 16'd1, 2'd0, 1'b1);
    drive(1'b1, 16'd2, 2'd0, 1'b0);
    drive(1'b1, 16'd3, 2'd0, 1'b0);
    drive(1'b1, 16'd3, 2'd0, 1'b1);
    drive(1'b1, 16'd3, 2'd0, 1'b1);
    drive(1'b1, 16'd4, 2'd0, 1'b1);
    drive(1'b1, 16'd5, 2'd0, 1'b1);
    drive(1'b0, 16'd0, 2'd0, 1'b1);
    checks++;
    if (stat_cnt !== 32'd5 || stat_cnt !== 32'(stat_m)) begin
      errors++; $display("FAIL stat_count: got %0d want 5 (model %0d)", stat_cnt, stat_m);
    end
    force dut.stat_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.stat_cnt_q;
    stat_m = 32'hFFFFFFFF;
    drive(1'b1, 16'd9, 2'd0, 1'b1);
    drive(1'b0, 16'd0, 2'd0, 1'b1);
    checks++;
    if (stat_cnt !== 32'h0 || stat_cnt !== 32'(stat_m)) begin
      errors++; $display("FAIL stat_wrap: got %h want 00000000", stat_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_modes();
    test_positive();
    test_backpressure();
    test_reset_mid();
    test_param();
    test_random();
`ifdef EXT_PIPE_STAT_EN
    test_stat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, registered immediate extender for the datapath, feeding the ALU-B and branch-target muxes.
- Generalises the plain 16->32 zero/sign extender in three ways: configurable input and output widths, four extension modes, and a valid/ready pipeline stage with a 2-entry skid buffer so it can sit between pipeline registers.
- Full throughput, 1-cycle latency.

Parameters:
- IN_W, 16, immediate width. Legal range: 2 <= IN_W <= OUT_W.
- OUT_W, 32, extended result width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream holds a valid imm/op
- in_ready  out  1  stage can accept; equals NOT skid_valid (register-driven, no combinational path from out_ready)
- imm  in  IN_W  raw immediate
- op  in  2  extension mode
- out_valid  out  1  ext_out is valid
- out_ready  in  1  downstream accepts
- ext_out  out  OUT_W  extended result

Behaviour:
- Handshakes: fire_in = in_valid & in_ready; fire_out = out_valid & out_ready.
- Mode arithmetic, computed combinationally from imm/op at accept time, result stored:
  - op=00 zero: {(OUT_W-IN_W) zeros, imm}
  - op=01 sign: {(OUT_W-IN_W) copies of imm[IN_W-1], imm}
  - op=10 upper: imm placed in ext_out[OUT_W-1:OUT_W-IN_W], low bits zero (lui form)
  - op=11 branch: sign-extend to OUT_W, then shift left 2, truncated to OUT_W
- State: main register (out_valid, ext_out); skid register (skid_valid, skid_data).
- Transitions:
  - main empty: on fire_in, main <= result and out_valid <= 1. Skid is always empty in this case.
  - main full, fire_out, skid empty: if fire_in, main <= result; else out_valid <= 0.
  - main full, fire_out, skid full: main <= skid_data; skid_valid <= 0. in_ready was 0, so no fire_in this cycle.
  - main full, no fire_out: on fire_in, skid <= result and skid_valid <= 1. in_ready drops next cycle.
- Throughput and latency: one result per cycle sustained when out_ready is held at 1. Latency is exactly 1 cycle from fire_in to out_valid.
- Ordering: results leave strictly in acceptance order. No drop, no duplicate.
- Output stability: ext_out holds its value while out_valid=1 and out_ready=0.
- Inputs ignored when in_ready=0: imm and op are not sampled.
- Reset values: out_valid=0, ext_out=0, skid_valid=0, skid_data=0, in_ready=1 (also 1 while reset is held).
- Reset asserted mid-transfer: both entries are discarded immediately and asynchronously. There is no output pulse on release.
- Simultaneous fire_in and fire_out with main full and skid empty: new result replaces main in the same edge. Skid stays empty.

Optional Feature:
- Macro: EXT_PIPE_STAT_EN.
- With the macro defined:
  - Adds output port stat_cnt (out, 32), a count of fire_out events.
  - Increments by 1 per fire_out and wraps 0xFFFFFFFF -> 0.
  - Reset value 0.
- Without the macro: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Defaults, out_ready=1: imm=0x8001 with op=00/01/10/11 on consecutive cycles -> ext_out = 0x00008001, 0xFFFF8001, 0x80010000, 0xFFFE0004 on the following 4 cycles, out_valid high throughout.
- Positive immediate: imm=0x7FFF, op=11 -> 0x0001FFFC. imm=0x7FFF, op=01 -> 0x00007FFF.
- Backpressure:
  - Hold out_ready=0 and offer A=0x0001, B=0x0002, C=0x0003 (op=00). A and B are accepted; in_ready=0 from the cycle after B is accepted; C is held.
  - Raise out_ready -> outputs 0x1, 0x2, 0x3 in order, each exactly once.
- Reset mid-operation:
  - Fill both entries, then pulse reset off-edge -> out_valid=0 and in_ready=1 immediately.
  - After release, send imm=0x00FF, op=01 -> 0x000000FF after 1 cycle; no stale data appears.
- Parameter sweep: IN_W=8, OUT_W=16, imm=0x80 -> op 00 = 0x0080, 01 = 0xFF80, 10 = 0x8000, 11 = 0xFE00.
- EXT_PIPE_STAT_EN: 5 transfers with 2 stall cycles -> stat_cnt=5. Preload via force to 0xFFFFFFFF, then one transfer -> stat_cnt=0.
